// File: rtl/ddr_wb_bridge_if.sv
// Wishbone B3 classic bus bundle between the system arbiter (master) and ddr_wb_bridge (slave).
interface ddr_wb_bridge_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat_w, sel, we, cyc, stb, input  dat_r, ack, err);
  modport slave  (input  adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/ddr_wb_bridge.sv
// Wishbone B3 classic slave to DDR controller local-interface bridge; one access at a time, phy_clk domain.
// Define DDR_WB_BRIDGE_WRITE_POST_EN to ack writes on acceptance and drain them to the controller in the background.
module ddr_wb_bridge #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned RD_TIMEOUT = 1023
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk,
  ddr_wb_bridge_if.slave    wb,
  output logic [ADDR_W-1:0] local_address,
  output logic [3:0]        local_be,
  output logic [31:0]       local_wdata,
  output logic              local_read_req,
  output logic              local_write_req,
  output logic              local_burstbegin,
  output logic [1:0]        local_size,
  input  logic              local_ready,
  input  logic              local_wdata_req,
  input  logic              local_rdata_valid,
  input  logic              local_init_done,
  input  logic [31:0]       local_rdata
);
  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DATA, ACK} state_t;

  // A posted write was already acked when it was sampled, so its drain ends straight in IDLE.
`ifdef DDR_WB_BRIDGE_WRITE_POST_EN
  localparam state_t WR_DONE = IDLE;
`else
  localparam state_t WR_DONE = ACK;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_timeout;
  logic             abort_q;
  logic             accept;
  logic             read_req_d;
  logic             write_req_d;
  logic             ack_d;
  logic             err_d;
  logic             unused_adr;

  assign accept     = (state == IDLE) && wb.cyc && wb.stb && local_init_done;
  assign rd_timeout = (rd_cnt == CNT_W'(RD_TIMEOUT));
  assign local_size = 2'd1;
  assign unused_adr = ^{wb.adr[31:ADDR_W+2], wb.adr[1:0]};

  // State register.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; rdata_valid wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = wb.we ? WR_REQ : RD_REQ;
      RD_REQ:  if (local_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (local_rdata_valid || rd_timeout) state_nxt = ACK;
      WR_REQ:  if (local_ready) state_nxt = local_wdata_req ? WR_DONE : WR_DATA;
      WR_DATA: if (local_wdata_req) state_nxt = WR_DONE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode against the state being entered so the registered outputs line up with it.
  always_comb begin
    read_req_d  = 1'b0;
    write_req_d = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    read_req_d  = (state_nxt == RD_REQ);
    write_req_d = (state_nxt == WR_REQ);
    if ((state_nxt == ACK) && wb.cyc && !abort_q) begin
      if ((state == RD_WAIT) && !local_rdata_valid) err_d = 1'b1;
      else                                          ack_d = 1'b1;
    end
`ifdef DDR_WB_BRIDGE_WRITE_POST_EN
    if (accept && wb.we) ack_d = 1'b1;
`endif
  end

  // Output registers.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      local_read_req   <= 1'b0;
      local_write_req  <= 1'b0;
      local_burstbegin <= 1'b0;
      wb.ack           <= 1'b0;
      wb.err           <= 1'b0;
    end else begin
      local_read_req   <= read_req_d;
      local_write_req  <= write_req_d;
      local_burstbegin <= read_req_d | write_req_d;
      wb.ack           <= ack_d;
      wb.err           <= err_d;
    end
  end

  // Access latch, read-data capture, read watchdog and cyc-abort tracking.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      local_address <= '0;
      local_be      <= '0;
      local_wdata   <= '0;
      wb.dat_r      <= '0;
      rd_cnt        <= '0;
      abort_q       <= 1'b0;
    end else begin
      if (accept) begin
        local_address <= wb.adr[ADDR_W+1:2];
        local_be      <= wb.sel;
        local_wdata   <= wb.dat_w;
        abort_q       <= 1'b0;
      end else if ((state != IDLE) && !wb.cyc) begin
        abort_q <= 1'b1;
      end
      if ((state == RD_WAIT) && local_rdata_valid) wb.dat_r <= local_rdata;
      if (state == RD_WAIT) rd_cnt <= rd_cnt + CNT_W'(1);
      else                  rd_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_ddr_wb_bridge.sv
// Directed + randomized bench for ddr_wb_bridge; the bench plays both the Wishbone master and the DDR controller.
module tb_ddr_wb_bridge;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned RD_TO  = 15;

  logic              phy_clk = 1'b0;
  logic              reset_phy_clk;
  logic [ADDR_W-1:0] local_address;
  logic [3:0]        local_be;
  logic [31:0]       local_wdata;
  logic              local_read_req, local_write_req, local_burstbegin;
  logic [1:0]        local_size;
  logic              local_ready, local_wdata_req, local_rdata_valid, local_init_done;
  logic [31:0]       local_rdata;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_rd;
  logic [31:0] ref_mem  [int];   // memory as seen through Wishbone semantics
  logic [31:0] ctrl_mem [int];   // memory as built from what the bridge actually presented

  ddr_wb_bridge_if wb();

  ddr_wb_bridge #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TO)) dut (
    .phy_clk(phy_clk), .reset_phy_clk(reset_phy_clk), .wb(wb),
    .local_address(local_address), .local_be(local_be), .local_wdata(local_wdata),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_ready(local_ready), .local_wdata_req(local_wdata_req),
    .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
    .local_rdata(local_rdata)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge phy_clk);
    #1;
  endtask

  function automatic logic [31:0] init_val(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] ctrl_rd(input int w);
    return ctrl_mem.exists(w) ? ctrl_mem[w] : init_val(w);
  endfunction

  task automatic wb_read(input logic [31:0] addr, input int rdy_dly, input int rv_dly, input bit drop_cyc);
    int w;
    logic [31:0] exp_d;
    w = int'(addr >> 2) & ((1 << ADDR_W) - 1);
    exp_d = ref_rd(w);
    wb.adr = addr; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
    step();
    chk("rd_req_issue", 32'({local_read_req, local_burstbegin, local_write_req}), 32'h6);
    chk("rd_addr", 32'(local_address), 32'(w));
    repeat (rdy_dly) begin
      step();
      chk("rd_req_hold", 32'({local_read_req, wb.ack}), 32'h2);
    end
    local_ready = 1'b1;
    step();
    local_ready = 1'b0;
    chk("rd_req_drop", 32'({local_read_req, local_burstbegin}), 32'h0);
    if (drop_cyc) begin wb.cyc = 1'b0; wb.stb = 1'b0; end
    repeat (rv_dly) begin
      step();
      chk("rd_early_ack", 32'({wb.ack, wb.err}), 32'h0);
    end
    local_rdata = ctrl_rd(int'(local_address));
    local_rdata_valid = 1'b1;
    step();
    local_rdata_valid = 1'b0;
    local_rdata = $urandom;
    chk("rd_ack", 32'({wb.ack, wb.err}), drop_cyc ? 32'h0 : 32'h2);
    chk("rd_data", wb.dat_r, exp_d);
    last_rd = exp_d;
    wb.cyc = 1'b0; wb.stb = 1'b0;
    step();
    chk("rd_ack_single", 32'({wb.ack, wb.err}), 32'h0);
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                          input int rdy_dly, input int wd_dly);
    int w;
    w = int'(addr >> 2) & ((1 << ADDR_W) - 1);
    wb.adr = addr; wb.dat_w = data; wb.sel = sel; wb.we = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
    step();
    chk("wr_req_issue", 32'({local_write_req, local_burstbegin, local_read_req}), 32'h6);
    chk("wr_addr", 32'(local_address), 32'(w));
    chk("wr_be", 32'(local_be), 32'(sel));
    chk("wr_data", local_wdata, data);
`ifdef DDR_WB_BRIDGE_WRITE_POST_EN
    chk("wr_post_ack", 32'({wb.ack, wb.err}), 32'h2);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.dat_w = ~data; wb.sel = ~sel;
`endif
    ref_mem[w] = merge(ref_rd(w), data, sel);
    repeat (rdy_dly) begin
      step();
      chk("wr_req_hold", 32'({local_write_req, local_burstbegin, wb.ack}), 32'h6);
      chk("wr_data_hold", local_wdata, data);
    end
    local_ready = 1'b1;
    local_wdata_req = (wd_dly == 0);
    if (wd_dly == 0) ctrl_mem[int'(local_address)] = merge(ctrl_rd(int'(local_address)), local_wdata, local_be);
    step();
    local_ready = 1'b0; local_wdata_req = 1'b0;
    chk("wr_req_drop", 32'({local_write_req, local_burstbegin}), 32'h0);
    repeat ((wd_dly > 0) ? wd_dly - 1 : 0) begin
      chk("wr_early_ack", 32'({wb.ack, wb.err}), 32'h0);
      step();
      chk("wr_data_stable", local_wdata, data);
    end
    if (wd_dly > 0) begin
      chk("wr_pre_ack", 32'({wb.ack, wb.err}), 32'h0);
      ctrl_mem[int'(local_address)] = merge(ctrl_rd(int'(local_address)), local_wdata, local_be);
      local_wdata_req = 1'b1;
      step();
      local_wdata_req = 1'b0;
    end
`ifdef DDR_WB_BRIDGE_WRITE_POST_EN
    chk("wr_ack", 32'({wb.ack, wb.err}), 32'h0);
`else
    chk("wr_ack", 32'({wb.ack, wb.err}), 32'h2);
`endif
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    step();
    chk("wr_ack_single", 32'({wb.ack, wb.err}), 32'h0);
  endtask

  initial begin
    reset_phy_clk = 1'b1;
    wb.adr = '0; wb.dat_w = '0; wb.sel = '0; wb.we = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;
    local_ready = 1'b0; local_wdata_req = 1'b0; local_rdata_valid = 1'b0;
    local_init_done = 1'b1; local_rdata = '0; last_rd = '0;
    repeat (3) step();
    chk("rst_ctl", 32'({local_read_req, local_write_req, local_burstbegin, wb.ack, wb.err}), 32'h0);
    chk("rst_size", 32'(local_size), 32'h1);
    chk("rst_dat", wb.dat_r, 32'h0);
    chk("rst_addr", 32'(local_address), 32'h0);
    chk("rst_wdata_be", local_wdata | 32'(local_be), 32'h0);
    reset_phy_clk = 1'b0;

    // Reset while waiting for read data, then a stray rdata_valid.
    wb.adr = 32'h40; wb.we = 1'b0; wb.cyc = 1'b1; wb.stb = 1'b1;
    step();
    local_ready = 1'b1;
    step();
    local_ready = 1'b0;
    chk("rst_pre_wait", 32'(local_read_req), 32'h0);
    reset_phy_clk = 1'b1; wb.cyc = 1'b0; wb.stb = 1'b0;
    repeat (3) begin
      step();
      chk("rst_mid_wait", 32'({local_read_req, local_write_req, local_burstbegin, wb.ack, wb.err}), 32'h0);
    end
    reset_phy_clk = 1'b0;
    local_rdata = 32'h1111_2222; local_rdata_valid = 1'b1;
    repeat (2) begin
      step();
      chk("rst_stray_ack", 32'({wb.ack, wb.err}), 32'h0);
      chk("rst_stray_dat", wb.dat_r, 32'h0);
    end
    local_rdata_valid = 1'b0;

    // Directed read and write from the test plan.
    ref_mem[4] = 32'hDEAD_BEEF; ctrl_mem[4] = 32'hDEAD_BEEF;
    wb_read(32'h0000_0010, 0, 5, 1'b0);
    chk("spec_rd_data", wb.dat_r, 32'hDEAD_BEEF);
    wb_write(32'h0000_0100, 32'h1234_5678, 4'h3, 5, 2);

    // Access stalls until the controller finishes initialisation.
    local_init_done = 1'b0;
    wb.adr = 32'h0000_0104; wb.we = 1'b0; wb.cyc = 1'b1; wb.stb = 1'b1;
    repeat (20) begin
      step();
      chk("init_stall", 32'({local_read_req, local_burstbegin, wb.ack}), 32'h0);
    end
    local_init_done = 1'b1;
    wb_read(32'h0000_0104, 1, 0, 1'b0);

    // cyc dropped mid-read: controller side completes, no termination.
    wb_read(32'h0000_0100, 1, 2, 1'b1);

    // Randomized mix over a small aliasing address window.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom & 32'hFE00_003F;
      if ($urandom_range(0, 1) == 1)
        wb_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        wb_read(a, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
    end

`ifdef DDR_WB_BRIDGE_WRITE_POST_EN
    // Posted write followed at once by a read of the same word: read waits for the drain.
    wb.adr = 32'h200; wb.dat_w = 32'hCAFE_F00D; wb.sel = 4'hF; wb.we = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
    step();
    chk("post_wr_ack", 32'({wb.ack, local_write_req}), 32'h3);
    ref_mem[32'h80] = 32'hCAFE_F00D;
    wb.we = 1'b0;
    local_ready = 1'b1;
    step();
    local_ready = 1'b0;
    chk("post_rd_stall0", 32'({local_read_req, wb.ack}), 32'h0);
    step();
    chk("post_rd_stall1", 32'({local_read_req, wb.ack}), 32'h0);
    ctrl_mem[int'(local_address)] = merge(ctrl_rd(int'(local_address)), local_wdata, local_be);
    local_wdata_req = 1'b1;
    step();
    local_wdata_req = 1'b0;
    chk("post_rd_stall2", 32'(local_read_req), 32'h0);
    step();
    chk("post_rd_issue", 32'(local_read_req), 32'h1);
    chk("post_rd_addr", 32'(local_address), 32'h80);
    local_ready = 1'b1;
    step();
    local_ready = 1'b0;
    local_rdata = ctrl_rd(int'(local_address)); local_rdata_valid = 1'b1;
    step();
    local_rdata_valid = 1'b0;
    chk("post_rd_ack", 32'({wb.ack, wb.err}), 32'h2);
    chk("post_rd_data", wb.dat_r, 32'hCAFE_F00D);
    last_rd = 32'hCAFE_F00D;
    wb.cyc = 1'b0; wb.stb = 1'b0;
    step();
`endif

    // Read watchdog: err exactly RD_TO+1 cycles after acceptance, late data ignored.
    wb.adr = 32'h0000_0080; wb.we = 1'b0; wb.cyc = 1'b1; wb.stb = 1'b1;
    step();
    chk("to_req", 32'(local_read_req), 32'h1);
    local_ready = 1'b1;
    step();
    local_ready = 1'b0;
    for (int k = 1; k <= int'(RD_TO); k++) begin
      step();
      chk("to_wait", 32'({wb.ack, wb.err}), 32'h0);
    end
    step();
    chk("to_err", 32'({wb.ack, wb.err}), 32'h1);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    local_rdata = 32'hBAD0_BAD0; local_rdata_valid = 1'b1;
    repeat (2) begin
      step();
      chk("to_stray_term", 32'({wb.ack, wb.err}), 32'h0);
      chk("to_stray_dat", wb.dat_r, last_rd);
    end
    local_rdata_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
